// File: rtl/carrier_loop_sequencer.sv
// Acquisition/tracking sequencer for the trellis carrier loop.
// Gear-shifts loop-filter exponents and sweeps the DDS offset until lock.
module carrier_loop_sequencer #(
    parameter int CNT_W   = 16,
    parameter int SWEEP_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               loopEn,
    input  logic               runEnable,
    input  logic               carrierLock,
    input  logic [4:0]         acqLeadExp,
    input  logic [4:0]         acqLagExp,
    input  logic [4:0]         trkLeadExp,
    input  logic [4:0]         trkLagExp,
    input  logic [CNT_W-1:0]   settleCount,
    input  logic [CNT_W-1:0]   trackDwell,
    input  logic [SWEEP_W-1:0] sweepStep,
    input  logic [SWEEP_W-1:0] sweepLimit,
    output logic [4:0]         leadExp,
    output logic [4:0]         lagExp,
    output logic               clearAccum,
    output logic               zeroError,
    output logic [SWEEP_W-1:0] sweepOffset,
    output logic [1:0]         state,
    output logic               trackMode,
    output logic [7:0]         relockCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACQUIRE = 2'd2,
        TRACK   = 2'd3
    } state_t;

    localparam int XW = SWEEP_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   INC_ONE = {{CNT_W{1'b0}}, 1'b1};

    state_t             cur_q, nxt;
    logic [CNT_W-1:0]   settle_q, settle_n;
    logic [CNT_W-1:0]   dwell_q, dwell_n;
    logic [CNT_W:0]     dwell_inc;
    logic               down_q, down_n;
    logic [SWEEP_W-1:0] off_q, off_n;
    logic [7:0]         relock_q, relock_n;

    // Two guard bits keep offset +/- a full-range step exact.
    logic signed [XW-1:0] off_x, step_x, lim_x, neg_lim, up_x, dn_x;
    logic [SWEEP_W-1:0]   sweep_off;
    logic                 sweep_down;

    assign off_x   = {{2{off_q[SWEEP_W-1]}}, off_q};
    assign step_x  = {2'b00, sweepStep};
    assign lim_x   = {2'b00, sweepLimit & {1'b0, {(SWEEP_W-1){1'b1}}}};
    assign neg_lim = -lim_x;
    assign up_x    = off_x + step_x;
    assign dn_x    = off_x - step_x;

    assign dwell_inc = {1'b0, dwell_q} + INC_ONE;

    always_comb begin
        sweep_off  = off_q;
        sweep_down = down_q;
        if (!down_q) begin
            if (up_x > lim_x) begin
                sweep_off  = lim_x[SWEEP_W-1:0];
                sweep_down = 1'b1;
            end else begin
                sweep_off = up_x[SWEEP_W-1:0];
            end
        end else begin
            if (dn_x < neg_lim) begin
                sweep_off  = neg_lim[SWEEP_W-1:0];
                sweep_down = 1'b0;
            end else begin
                sweep_off = dn_x[SWEEP_W-1:0];
            end
        end
    end

    always_comb begin
        nxt      = cur_q;
        settle_n = settle_q;
        dwell_n  = dwell_q;
        down_n   = down_q;
        off_n    = off_q;
        relock_n = relock_q;
        if (!runEnable) begin
            nxt = IDLE;
        end else if (loopEn) begin
            unique case (cur_q)
                IDLE: begin
                    nxt      = SETTLE;
                    settle_n = settleCount;
                end
                SETTLE: begin
                    if (settle_q != '0) begin
                        settle_n = settle_q - CNT_ONE;
                    end else begin
                        nxt     = ACQUIRE;
                        dwell_n = '0;
                    end
                end
                ACQUIRE: begin
                    if (carrierLock) begin
                        if (dwell_inc >= {1'b0, trackDwell}) begin
                            nxt     = TRACK;
                            dwell_n = '0;
                        end else begin
                            dwell_n = dwell_inc[CNT_W-1:0];
                        end
                    end else begin
                        dwell_n = '0;
                        off_n   = sweep_off;
                        down_n  = sweep_down;
                    end
                end
                TRACK: begin
                    if (!carrierLock) begin
                        nxt = ACQUIRE;
                        if (relock_q != 8'hFF) begin
                            relock_n = relock_q + 8'd1;
                        end
                    end
                end
                default: nxt = IDLE;
            endcase
        end
        if (nxt == IDLE) begin
            settle_n = '0;
            dwell_n  = '0;
            down_n   = 1'b0;
            off_n    = '0;
            relock_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q      <= IDLE;
            settle_q   <= '0;
            dwell_q    <= '0;
            down_q     <= 1'b0;
            off_q      <= '0;
            relock_q   <= '0;
            leadExp    <= '0;
            lagExp     <= '0;
            clearAccum <= 1'b1;
            zeroError  <= 1'b1;
            trackMode  <= 1'b0;
        end else begin
            cur_q      <= nxt;
            settle_q   <= settle_n;
            dwell_q    <= dwell_n;
            down_q     <= down_n;
            off_q      <= off_n;
            relock_q   <= relock_n;
            leadExp    <= (nxt == TRACK) ? trkLeadExp : acqLeadExp;
            lagExp     <= (nxt == TRACK) ? trkLagExp : acqLagExp;
            clearAccum <= (nxt == IDLE);
            zeroError  <= (nxt == IDLE);
            trackMode  <= (nxt == TRACK);
        end
    end

    assign state       = cur_q;
    assign sweepOffset = off_q;
    assign relockCount = relock_q;

endmodule

// File: tb/tb_carrier_loop_sequencer.sv
// Bench for carrier_loop_sequencer: directed steps plus random strobes,
// checked against an arithmetic model of the acquisition sequence.
module tb_carrier_loop_sequencer;

    logic        clk = 1'b0;
    logic        reset, loopEn, runEnable, carrierLock;
    logic [4:0]  acqLeadExp, acqLagExp, trkLeadExp, trkLagExp;
    logic [15:0] settleCount, trackDwell;
    logic [31:0] sweepStep, sweepLimit;
    logic [4:0]  leadExp, lagExp;
    logic        clearAccum, zeroError, trackMode;
    logic [31:0] sweepOffset;
    logic [1:0]  state;
    logic [7:0]  relockCount;

    always #5 clk = ~clk;

    carrier_loop_sequencer dut (
        .clk(clk), .reset(reset), .loopEn(loopEn),
        .runEnable(runEnable), .carrierLock(carrierLock),
        .acqLeadExp(acqLeadExp), .acqLagExp(acqLagExp),
        .trkLeadExp(trkLeadExp), .trkLagExp(trkLagExp),
        .settleCount(settleCount), .trackDwell(trackDwell),
        .sweepStep(sweepStep), .sweepLimit(sweepLimit),
        .leadExp(leadExp), .lagExp(lagExp),
        .clearAccum(clearAccum), .zeroError(zeroError),
        .sweepOffset(sweepOffset), .state(state),
        .trackMode(trackMode), .relockCount(relockCount)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: state 0..3, offset as a plain signed integer, direction +/-1.
    int          m_st, m_settle, m_dwell, m_dir, m_relock;
    longint      m_off;
    logic [4:0]  m_lead, m_lag;
    logic        m_clear, m_zero, m_trk;
    logic [31:0] sweep_tbl [12];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_settle = 0; m_dwell = 0; m_dir = 1;
        m_relock = 0; m_off = 0;
        m_lead = '0; m_lag = '0;
        m_clear = 1'b1; m_zero = 1'b1; m_trk = 1'b0;
    endtask

    task automatic model_edge();
        int     st;
        longint lim, nx;
        st = m_st;
        if (!runEnable) begin
            st = 0;
        end else if (loopEn) begin
            case (m_st)
                0: begin st = 1; m_settle = int'(settleCount); end
                1: begin
                    if (m_settle > 0) m_settle--;
                    else begin st = 2; m_dwell = 0; end
                end
                2: begin
                    if (carrierLock) begin
                        m_dwell++;
                        if (m_dwell >= int'(trackDwell)) begin
                            st = 3; m_dwell = 0;
                        end
                    end else begin
                        m_dwell = 0;
                        lim = longint'(sweepLimit & 32'h7fff_ffff);
                        nx  = m_off + m_dir * longint'(sweepStep);
                        if (m_dir > 0 && nx > lim) begin
                            m_off = lim; m_dir = -1;
                        end else if (m_dir < 0 && nx < -lim) begin
                            m_off = -lim; m_dir = 1;
                        end else begin
                            m_off = nx;
                        end
                    end
                end
                default: begin
                    if (!carrierLock) begin
                        st = 2;
                        if (m_relock < 255) m_relock++;
                    end
                end
            endcase
        end
        if (st == 0) begin
            m_off = 0; m_dir = 1; m_relock = 0; m_settle = 0; m_dwell = 0;
        end
        m_st    = st;
        m_lead  = (st == 3) ? trkLeadExp : acqLeadExp;
        m_lag   = (st == 3) ? trkLagExp : acqLagExp;
        m_clear = (st == 0);
        m_zero  = (st == 0);
        m_trk   = (st == 3);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_off;
        e_off = m_off[31:0];
        chk({tag, ".state"}, {30'd0, state}, m_st[31:0]);
        chk({tag, ".lead"}, {27'd0, leadExp}, {27'd0, m_lead});
        chk({tag, ".lag"}, {27'd0, lagExp}, {27'd0, m_lag});
        chk({tag, ".clear"}, {31'd0, clearAccum}, {31'd0, m_clear});
        chk({tag, ".zero"}, {31'd0, zeroError}, {31'd0, m_zero});
        chk({tag, ".trk"}, {31'd0, trackMode}, {31'd0, m_trk});
        chk({tag, ".offset"}, sweepOffset, e_off);
        chk({tag, ".relock"}, {24'd0, relockCount}, m_relock[31:0]);
    endtask

    task automatic step(input logic run, input logic en, input logic lock);
        runEnable   = run;
        loopEn      = en;
        carrierLock = lock;
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
    endtask

    initial begin
        sweep_tbl = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                      32'h3000_0000, 32'h2000_0000, 32'h1000_0000,
                      32'h0000_0000, 32'hF000_0000, 32'hE000_0000,
                      32'hD000_0000, 32'hD000_0000, 32'hE000_0000};
        reset = 1'b0; runEnable = 1'b0; loopEn = 1'b0; carrierLock = 1'b0;
        acqLeadExp = 5'd3;  acqLagExp = 5'd9;
        trkLeadExp = 5'd12; trkLagExp = 5'd20;
        settleCount = 16'd3; trackDwell = 16'd5;
        sweepStep = '0; sweepLimit = '0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;
        #2;

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("enter_settle", {30'd0, state}, 32'd1);
        chk("settle_clear", {31'd0, clearAccum}, 32'd0);

        repeat (4) begin
            repeat (3) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        chk("enter_acq", {30'd0, state}, 32'd2);
        chk("acq_lead", {27'd0, leadExp}, 32'd3);

        sweepStep  = 32'h1000_0000;
        sweepLimit = 32'h3000_0000;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("sweep%0d", i), sweepOffset, sweep_tbl[i]);
        end

        repeat (4) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b1);
        chk("dwell_4", {30'd0, state}, 32'd2);
        step(1'b1, 1'b1, 1'b1);
        chk("dwell_5", {30'd0, state}, 32'd3);
        chk("trk_lead", {27'd0, leadExp}, 32'd12);
        repeat (3) step(1'b1, 1'b1, 1'b1);

        trackDwell = 16'd1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'($urandom));
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1);
        end
        chk("relock_sat", {24'd0, relockCount}, 32'd255);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sweepStep   = ($urandom_range(0, 3) == 0) ? 32'd0
                            : ($urandom >> $urandom_range(0, 31));
                sweepLimit  = $urandom;
                settleCount = 16'($urandom_range(0, 3));
                trackDwell  = 16'($urandom_range(0, 4));
                acqLeadExp  = 5'($urandom); acqLagExp = 5'($urandom);
                trkLeadExp  = 5'($urandom); trkLagExp = 5'($urandom);
            end
            step(1'($urandom_range(0, 99) > 3), 1'($urandom_range(0, 2) != 0),
                 1'($urandom));
        end

        settleCount = 16'd0; trackDwell = 16'd1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("pre_override", {30'd0, state}, 32'd3);
        step(1'b0, 1'b1, 1'b0);
        chk("override_trk", {30'd0, state}, 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("override_acq", {30'd0, state}, 32'd0);

        settleCount = 16'd100;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_settle", {30'd0, state}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_clear", {31'd0, clearAccum}, 32'd1);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
